// File: rtl/trap_csr_unit.sv
// ============================================================================
// trap_csr_unit : machine-mode trap, interrupt and Zicsr CSR unit.
// Optional 64-bit mcycle counter when MCYCLE_COUNTER_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trap_csr_unit #(
    parameter int              XLEN        = 32,
    parameter int              NUM_IRQ     = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Di_valid,
    input  logic [XLEN-1:0]    Di_PC,
    input  logic               Di_ecall,
    input  logic               Di_ebreak,
    input  logic               Di_illegal,
    input  logic               Di_mret,
    input  logic [1:0]         Di_csrOp,
    input  logic [11:0]        Di_csrAddr,
    input  logic [XLEN-1:0]    Di_csrWdata,
    input  logic [NUM_IRQ-1:0] Di_irq,
    output logic               Do_trap,
    output logic [XLEN-1:0]    Do_mtvecTarget,
    output logic [XLEN-1:0]    Do_mepc,
    output logic [XLEN-1:0]    Do_csrRdata,
    output logic               Do_csrIllegal
);

    localparam logic [11:0] c_ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] c_ADDR_MIE      = 12'h304;
    localparam logic [11:0] c_ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] c_ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] c_ADDR_MEPC     = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] c_ADDR_MIP      = 12'h344;
`ifdef MCYCLE_COUNTER_EN
    localparam logic [11:0] c_ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] c_ADDR_MCYCLEH  = 12'hB80;
`endif

    logic [NUM_IRQ-1:0] r_irq_s1, r_irq_s2, r_mie_en;
    logic               r_mstatus_mie, r_mstatus_mpie;
    logic [XLEN-1:0]    r_mtvec, r_mscratch, r_mepc, r_mcause;
`ifdef MCYCLE_COUNTER_EN
    logic [63:0]        r_mcycle;
`endif

    logic [NUM_IRQ-1:0] w_pend;
    logic               w_irq_take, w_exc, w_trap, w_impl, w_csr_we;
    logic [4:0]         w_irq_idx, w_irq_code;
    logic [XLEN-1:0]    w_cause, w_base, w_target, w_rdata, w_new;

    // Trap selection and target; the lowest-numbered enabled pending line wins.
    always_comb begin
        w_pend     = r_irq_s2 & r_mie_en;
        w_irq_take = r_mstatus_mie & (|w_pend);
        w_irq_idx  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend[i]) w_irq_idx = 5'(i);
        end
        w_irq_code = 5'd16 + w_irq_idx;
        w_exc      = Di_illegal | Di_ebreak | Di_ecall;
        w_trap     = Di_valid & (w_exc | w_irq_take);
        w_cause    = '0;
        if (Di_illegal)      w_cause = XLEN'(2);
        else if (Di_ebreak)  w_cause = XLEN'(3);
        else if (Di_ecall)   w_cause = XLEN'(11);
        else begin
            w_cause[XLEN-1] = 1'b1;
            w_cause[4:0]    = w_irq_code;
        end
        w_base   = r_mtvec & ~XLEN'(3);
        w_target = w_base;
        if (!w_exc && w_irq_take && r_mtvec[0])
            w_target = w_base + XLEN'({w_irq_code, 2'b00});
    end

    // CSR read mux and read-modify-write value.
    always_comb begin
        w_rdata = '0;
        w_impl  = 1'b1;
        case (Di_csrAddr)
            c_ADDR_MSTATUS: begin
                w_rdata[3] = r_mstatus_mie;
                w_rdata[7] = r_mstatus_mpie;
            end
            c_ADDR_MIE:      w_rdata[16 +: NUM_IRQ] = r_mie_en;
            c_ADDR_MTVEC:    w_rdata = r_mtvec;
            c_ADDR_MSCRATCH: w_rdata = r_mscratch;
            c_ADDR_MEPC:     w_rdata = r_mepc;
            c_ADDR_MCAUSE:   w_rdata = r_mcause;
            c_ADDR_MIP:      w_rdata[16 +: NUM_IRQ] = r_irq_s2;
`ifdef MCYCLE_COUNTER_EN
            c_ADDR_MCYCLE:   w_rdata = XLEN'(r_mcycle[31:0]);
            c_ADDR_MCYCLEH:  w_rdata = XLEN'(r_mcycle[63:32]);
`endif
            default:         w_impl  = 1'b0;
        endcase
        case (Di_csrOp)
            2'b01:   w_new = Di_csrWdata;
            2'b10:   w_new = w_rdata | Di_csrWdata;
            2'b11:   w_new = w_rdata & ~Di_csrWdata;
            default: w_new = w_rdata;
        endcase
        w_csr_we = Di_valid && (Di_csrOp != 2'b00) && w_impl && !w_trap;
    end

    // Outputs are held at their reset values while reset is asserted.
    assign Do_trap        = w_trap & ~reset;
    assign Do_mtvecTarget = reset ? MTVEC_RESET : w_target;
    assign Do_mepc        = r_mepc;
    assign Do_csrRdata    = reset ? '0 : w_rdata;
    assign Do_csrIllegal  = ~reset & (Di_csrOp != 2'b00) & ~w_impl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_s1       <= '0;
            r_irq_s2       <= '0;
            r_mie_en       <= '0;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b1;
            r_mtvec        <= MTVEC_RESET;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
        end else begin
            r_irq_s1 <= Di_irq;
            r_irq_s2 <= r_irq_s1;
            if (w_trap) begin
                r_mepc         <= Di_PC & ~XLEN'(3);
                r_mcause       <= w_cause;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else begin
                if (Di_valid && Di_mret) begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end
                if (w_csr_we) begin
                    case (Di_csrAddr)
                        c_ADDR_MSTATUS: begin
                            r_mstatus_mie  <= w_new[3];
                            r_mstatus_mpie <= w_new[7];
                        end
                        c_ADDR_MIE:      r_mie_en   <= w_new[16 +: NUM_IRQ];
                        c_ADDR_MTVEC:    r_mtvec    <= w_new & ~XLEN'(2);
                        c_ADDR_MSCRATCH: r_mscratch <= w_new;
                        c_ADDR_MEPC:     r_mepc     <= w_new & ~XLEN'(3);
                        c_ADDR_MCAUSE:   r_mcause   <= w_new;
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef MCYCLE_COUNTER_EN
    // A software write to either half replaces the increment for that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcycle <= '0;
        end else if (w_csr_we && Di_csrAddr == c_ADDR_MCYCLE) begin
            r_mcycle[31:0] <= w_new[31:0];
        end else if (w_csr_we && Di_csrAddr == c_ADDR_MCYCLEH) begin
            r_mcycle[63:32] <= w_new[31:0];
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
- Machine-mode trap and CSR unit; next generation of the core's ecall/mret handler.
- Adds writable CSRs (Zicsr read/write/set/clear), several synchronous exception causes, NUM_IRQ external interrupt lines with enable and priority, and direct or vectored mtvec.
- Sits beside the controller in the single-cycle datapath.
- Supplies the trap target, mepc and CSR read data to the PC mux and the writeback mux.

Parameters:
- XLEN, 32, data/PC width.
- NUM_IRQ, 4, external interrupt lines (1..16); line i has cause 16+i and mie/mip bit 16+i.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Di_valid  in  1  instruction in the execute slot is valid; traps and CSR writes are qualified by it.
- Di_PC  in  XLEN  PC of the current instruction.
- Di_ecall  in  1  ecall decoded.
- Di_ebreak  in  1  ebreak decoded.
- Di_illegal  in  1  illegal instruction from the decoder.
- Di_mret  in  1  mret decoded.
- Di_csrOp  in  2  00 none, 01 write, 10 set, 11 clear.
- Di_csrAddr  in  12  CSR address.
- Di_csrWdata  in  XLEN  rs1 value or zimm, zero-extended.
- Di_irq  in  NUM_IRQ  asynchronous external interrupt levels.
- Do_trap  out  1  redirect the PC to Do_mtvecTarget this cycle.
- Do_mtvecTarget  out  XLEN  trap target PC.
- Do_mepc  out  XLEN  mret target PC.
- Do_csrRdata  out  XLEN  old value of the addressed CSR.
- Do_csrIllegal  out  1  unimplemented CSR address with Di_csrOp != 00.

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only bit 3 (MIE) and bit 7 (MPIE); all other bits read 0, writes ignored.
  - mie 0x304: bits [16+NUM_IRQ-1:16] implemented, others read 0.
  - mtvec 0x305: bit 1 is forced to 0 on write; mode = bit 0 (0 direct, 1 vectored).
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342: XLEN bits; MSB is the interrupt flag.
  - mip 0x344: read-only; reads the synchronised IRQs in bits [16+NUM_IRQ-1:16]; writes ignored, not illegal.
- Reset values: mepc=0, mcause=0, mscratch=0, mie=0, MIE=0, MPIE=1, mtvec=MTVEC_RESET, synchronisers=0.
- Reset output values: Do_trap=0, Do_mepc=0, Do_mtvecTarget=MTVEC_RESET, Do_csrRdata=0, Do_csrIllegal=0.
- IRQ path: each Di_irq bit goes through a 2-flop synchroniser into mip, so it is visible 2 cycles after its first sampling edge.
- Pending interrupt = MIE & |(mip & mie), evaluated on the registered state.
- Trap selection is combinational in the same cycle, gated by Di_valid.
- Priority, highest first:
  - Di_illegal, cause 2.
  - Di_ebreak, cause 3.
  - Di_ecall, cause 11.
  - Pending interrupt: lowest-numbered enabled line i wins; cause = {1'b1, 16+i}.
- Do_trap=1 when any of the above is selected.
- Do_mtvecTarget:
  - Direct mode, or any exception: {mtvec[XLEN-1:2], 2'b00}.
  - Vectored mode with an interrupt: that base + 4*(16+i), modulo 2^XLEN.
- Register updates at the next edge when a trap is taken:
  - mepc <= {Di_PC[XLEN-1:2], 2'b00}. This is the faulting or interrupted instruction itself; software adds 4 for ecall.
  - mcause <= selected cause.
  - MPIE <= MIE; MIE <= 0.
- mret with Di_valid and no trap: MIE <= MPIE, MPIE <= 1. Do_mepc is always the current mepc.
- CSR access:
  - Do_csrRdata is combinational: the current value at Di_csrAddr, or 0 if the address is unimplemented.
  - Write-back at the edge: write = Wdata, set = old | Wdata, clear = old & ~Wdata, with WARL masking applied.
  - A write happens only when Di_valid, op != 00, the address is implemented and no trap is taken.
- Simultaneous events:
  - Trap beats a CSR write and beats mret; both are dropped.
  - A CSR write to mstatus.MIE takes effect on the following cycle's interrupt evaluation.
  - Do_csrIllegal is reported, but does not itself trap. The decoder folds it into Di_illegal on the next attempt; within this block it is informational.
- Di_valid=0: no trap, no state change, synchronisers still shift.
- Reset mid-operation: all state returns to reset values immediately and asynchronously.

Optional Feature:
- Macro MCYCLE_COUNTER_EN.
- Defined: 64-bit mcycle counter, incremented every clock from 0 at reset.
  - Read at 0xB00 (low word) and 0xB80 (high word); writable via csrOp.
  - A write to either half replaces that half; that cycle's increment is suppressed.
  - Wraps from 2^64-1 to 0.
- Undefined: no counter; 0xB00 and 0xB80 are unimplemented and raise Do_csrIllegal.

Test Plan:
- Reset, then write mtvec=0x100 and mie bit16=1, and set mstatus.MIE via set of 0x8; raise Di_irq[0] -> Do_trap=1 on the 3rd cycle after the rising sample, target 0x100, mcause 0x8000_0010, mepc=PC, MIE=0, MPIE=1.
- mtvec=0x201 (vectored), irq lines 1 and 2 both pending and enabled -> cause 0x8000_0011, target 0x200+0x44=0x244; a read of mtvec returns 0x201.
- ecall at PC 0x40 with illegal also high -> cause 2, target = mtvec base, mepc 0x40; mret the next cycle -> MIE restored to previous MPIE, Do_mepc=0x40.
- csrrw to mscratch 0xDEAD_BEEF in the same cycle as ecall -> write dropped, mscratch still 0; repeat without ecall -> read-back 0xDEAD_BEEF; clear 0x0000_00EF -> 0xDEAD_BE00.
- Access to 0x7C0 -> Do_csrIllegal=1, Do_csrRdata=0, no state change; mip write of 0xFFFF_FFFF -> ignored, Do_csrIllegal=0.
- Assert reset mid-trap with mepc=0x80 -> all outputs at reset values immediately; with MCYCLE_COUNTER_EN, mcycle reads 0 and then increments by 1 per cycle.
